dir_controller: RTL
===================

DIR_CONTROLLER -- requirements
Module: dir_controller

Interface
REQ-001 SHALL have parameter REQ_HOLD, default 8: number of move_tick pulses a buffered request survives unserved.
REQ-002 SHALL have parameter MAX_X, default 26: last column before horizontal wrap to 0.
REQ-003 SHALL have parameter MAX_Y, default 23: last row before vertical wrap to 0.
REQ-004 SHALL provide clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL provide reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL provide key  input  4  raw buttons, [0]=right [1]=up [2]=left [3]=down, asynchronous to clk.
REQ-007 SHALL provide move_tick  input  1  one-cycle pulse marking a movement step.
REQ-008 SHALL provide x_in  input  8  current sprite column.
REQ-009 SHALL provide y_in  input  7  current sprite row.
REQ-010 SHALL provide req_px / req_py  output  8 / 7  neighbour cell of the buffered request (combinational).
REQ-011 SHALL provide req_wall  input  1  map result for req_px/req_py, 1 = wall.
REQ-012 SHALL provide cur_px / cur_py  output  8 / 7  neighbour cell of the current direction (combinational).
REQ-013 SHALL provide cur_wall  input  1  map result for cur_px/cur_py, 1 = wall.
REQ-014 SHALL provide dir_out  output  3  registered direction: 000 right, 001 up, 010 left, 011 down, 100 wait.
REQ-015 SHALL provide req_pending  output  1  registered; a buffered request is held.

Function
REQ-016 SHALL synchronise each key bit through two flops, then rising-edge detect it; only new presses create requests.
REQ-017 Simultaneous new presses SHALL resolve with priority right > up > left > down.
REQ-018 A new press SHALL overwrite any buffered request, set req_pending, and reload the hold counter to REQ_HOLD.
REQ-019 Neighbour cell: right x+1, up y-1, left x-1, down y+1; right at MAX_X gives 0, left at 0 gives MAX_X, up at 0 gives MAX_Y, down at MAX_Y gives 0.
REQ-020 With dir_out = wait, cur_px/cur_py SHALL equal x_in/y_in; with no request, req_px/req_py SHALL equal x_in/y_in.
REQ-021 States: STOPPED (dir_out = wait) and MOVING (dir_out = a direction).
REQ-022 On move_tick with req_pending=1 and req_wall=0: dir_out <= request, req_pending <= 0, state MOVING, next cycle.
REQ-023 On move_tick when REQ-022 does not apply and state MOVING with cur_wall=1: dir_out <= wait, state STOPPED; request, if any, is retained.
REQ-024 On move_tick when REQ-022 does not apply and cur_wall=0: dir_out unchanged.
REQ-025 On move_tick with req_pending=1 and not served: hold counter decrements; at 1 it clears req_pending instead.
REQ-026 A press coinciding with move_tick SHALL be buffered first and evaluated on the next move_tick.
REQ-027 A request equal to dir_out SHALL be cleared on the next clock without further effect.
REQ-028 Without move_tick, dir_out SHALL not change except per REQ-033.

Reset
REQ-029 Reset SHALL force dir_out = 100, req_pending = 0, state STOPPED, hold counter 0, synchroniser and edge flops 0, asynchronously.
REQ-030 Release of reset SHALL NOT create a request even if keys are held.
REQ-031 Reset asserted mid-operation SHALL discard any buffered request.

Configuration
REQ-032 Macro REVERSE_INSTANT_EN SHALL select instant reversal.
REQ-033 With REVERSE_INSTANT_EN defined: request opposite to a MOVING dir_out SHALL be applied next clock without move_tick or wall check, clearing req_pending.
REQ-034 Without REVERSE_INSTANT_EN: reversal requests follow REQ-022..REQ-025 like any other.

Verification
REQ-035 Reset with key=0001 held, release, 3 move_ticks, walls 0 -> dir_out stays 100, req_pending 0.
REQ-036 x_in=5,y_in=5, press key[0], walls 0, move_tick -> req_px=6,req_py=5; next cycle dir_out=000, req_pending=0.
REQ-037 dir_out=000 at x_in=26, cur_wall=0 -> cur_px=0, cur_py=y_in; move_tick keeps dir_out=000.
REQ-038 dir_out=000, press up with req_wall=1, 8 move_ticks cur_wall=0 -> dir_out 000 throughout, req_pending drops after 8th tick.
REQ-039 dir_out=001, cur_wall=1, no request, move_tick -> dir_out=100; then press left, req_wall=0, move_tick -> dir_out=010.
REQ-040 dir_out=000, press left, no move_tick -> with REVERSE_INSTANT_EN dir_out=010 two clocks after edge detect; without, dir_out remains 000 until move_tick.

Source files
------------

// File: rtl/dir_controller.sv
// dir_controller -- direction controller for a grid-walking sprite.
//
// Buttons are synchronised and edge detected; a new press is buffered as a
// request that is served on a later move_tick when its neighbour cell is not
// a wall. The buffered request expires after REQ_HOLD unserved move_ticks.
// The sprite stops when the cell ahead in the current direction is a wall.
//
// Optional feature macro: REVERSE_INSTANT_EN -- a request opposite to the
// current direction of travel is applied on the next clock, without waiting
// for move_tick and without a wall check.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous active-high reset
//   key[3:0]     raw buttons: [0] right, [1] up, [2] left, [3] down
//   move_tick    one-cycle pulse marking a movement step
//   x_in, y_in   current sprite column / row
//   req_px/py    neighbour cell of the buffered request (combinational)
//   req_wall     wall flag for req_px/req_py
//   cur_px/py    neighbour cell of the current direction (combinational)
//   cur_wall     wall flag for cur_px/cur_py
//   dir_out      registered direction: 0 right, 1 up, 2 left, 3 down, 4 wait
//   req_pending  registered: a buffered request is held
module dir_controller #(
    parameter int REQ_HOLD = 8,
    parameter int MAX_X    = 26,
    parameter int MAX_Y    = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key,
    input  logic       move_tick,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    output logic [7:0] req_px,
    output logic [6:0] req_py,
    input  logic       req_wall,
    output logic [7:0] cur_px,
    output logic [6:0] cur_py,
    input  logic       cur_wall,
    output logic [2:0] dir_out,
    output logic       req_pending
);

    localparam int          HW      = (REQ_HOLD < 2) ? 1 : $clog2(REQ_HOLD + 1);
    localparam logic [7:0]  MAX_X_C = 8'(MAX_X);
    localparam logic [6:0]  MAX_Y_C = 7'(MAX_Y);
    localparam logic [2:0]  DIR_WAIT = 3'd4;

    typedef enum logic {STOPPED = 1'b0, MOVING = 1'b1} state_t;

    logic [3:0]    key_s1_q, key_s2_q, key_prev_q;
    logic [1:0]    settle_q;
    state_t        state_q, state_d;
    logic [2:0]    dir_q, dir_d;
    logic [1:0]    req_dir_q, req_dir_d;
    logic          pend_q, pend_d;
    logic [HW-1:0] hold_q, hold_d;

    logic [3:0]    rise_s;
    logic          press_s;
    logic [1:0]    press_dir_s;
    logic          same_s, rev_s, stop_s;

    // Neighbour cell in direction d with wrap-around; wait leaves the cell unchanged.
    function automatic logic [14:0] neighbour(input logic [2:0] d,
                                              input logic [7:0] x,
                                              input logic [6:0] y);
        logic [7:0] nx;
        logic [6:0] ny;
        nx = x;
        ny = y;
        case (d)
            3'd0:    nx = (x == MAX_X_C) ? 8'd0 : x + 8'd1;
            3'd1:    ny = (y == 7'd0) ? MAX_Y_C : y - 7'd1;
            3'd2:    nx = (x == 8'd0) ? MAX_X_C : x - 8'd1;
            3'd3:    ny = (y == MAX_Y_C) ? 7'd0 : y + 7'd1;
            default: begin
                nx = x;
                ny = y;
            end
        endcase
        return {nx, ny};
    endfunction

    // Key synchroniser, edge-detect history and post-reset settle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_s1_q   <= 4'd0;
            key_s2_q   <= 4'd0;
            key_prev_q <= 4'd0;
            settle_q   <= 2'd0;
        end else begin
            key_s1_q   <= key;
            key_s2_q   <= key_s1_q;
            key_prev_q <= key_s2_q;
            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end
        end
    end

    // Edges are masked until the history holds genuine samples, so keys held
    // through reset release never look like new presses.
    assign rise_s = key_s2_q & ~key_prev_q & {4{settle_q == 2'd3}};

    // Priority encode simultaneous presses: right > up > left > down.
    always_comb begin
        press_s     = 1'b1;
        press_dir_s = 2'd0;
        if (rise_s[0]) begin
            press_dir_s = 2'd0;
        end else if (rise_s[1]) begin
            press_dir_s = 2'd1;
        end else if (rise_s[2]) begin
            press_dir_s = 2'd2;
        end else if (rise_s[3]) begin
            press_dir_s = 2'd3;
        end else begin
            press_s = 1'b0;
        end
    end

    assign same_s = pend_q && (state_q == MOVING) && (req_dir_q == dir_q[1:0]);
`ifdef REVERSE_INSTANT_EN
    // Opposite directions differ only in bit 1 of the direction code.
    assign rev_s  = pend_q && (state_q == MOVING) &&
                    (req_dir_q == {~dir_q[1], dir_q[0]});
`else
    assign rev_s  = 1'b0;
`endif
    assign stop_s = move_tick && (state_q == MOVING) && cur_wall;

    // Next-state logic for direction, movement state and the request buffer.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        req_dir_d = req_dir_q;
        pend_d    = pend_q;
        hold_d    = hold_q;
        if (press_s) begin
            // A fresh press replaces the buffer; it is not evaluated until the next tick.
            req_dir_d = press_dir_s;
            pend_d    = 1'b1;
            hold_d    = HW'(REQ_HOLD);
            if (stop_s) begin
                dir_d   = DIR_WAIT;
                state_d = STOPPED;
            end else begin
                dir_d   = dir_q;
            end
        end else if (same_s) begin
            pend_d = 1'b0;
            if (stop_s) begin
                dir_d   = DIR_WAIT;
                state_d = STOPPED;
            end else begin
                dir_d   = dir_q;
            end
        end else if (rev_s) begin
            dir_d   = {1'b0, req_dir_q};
            pend_d  = 1'b0;
            state_d = MOVING;
        end else if (move_tick) begin
            if (pend_q && !req_wall) begin
                dir_d   = {1'b0, req_dir_q};
                pend_d  = 1'b0;
                state_d = MOVING;
            end else begin
                if (stop_s) begin
                    dir_d   = DIR_WAIT;
                    state_d = STOPPED;
                end else begin
                    dir_d   = dir_q;
                end
                if (pend_q && (hold_q == HW'(1))) begin
                    pend_d = 1'b0;
                    hold_d = HW'(0);
                end else if (pend_q) begin
                    hold_d = hold_q - HW'(1);
                end else begin
                    hold_d = hold_q;
                end
            end
        end else begin
            dir_d = dir_q;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= STOPPED;
            dir_q     <= DIR_WAIT;
            req_dir_q <= 2'd0;
            pend_q    <= 1'b0;
            hold_q    <= HW'(0);
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            req_dir_q <= req_dir_d;
            pend_q    <= pend_d;
            hold_q    <= hold_d;
        end
    end

    // Neighbour cells presented to the map for wall lookup.
    always_comb begin
        {cur_px, cur_py} = neighbour(dir_q, x_in, y_in);
        if (pend_q) begin
            {req_px, req_py} = neighbour({1'b0, req_dir_q}, x_in, y_in);
        end else begin
            {req_px, req_py} = {x_in, y_in};
        end
    end

    assign dir_out     = dir_q;
    assign req_pending = pend_q;

endmodule
